fpa_mseq: RTL and testbench

Mantissa sequencer for the F-PA datapath. It turns a single start request into the cycle-by-cycle control word that drives the T, M and C registers, K-bus select and ALU mode, for two operations: 40-step two's-complement mantissa multiply and left normalization. It sits between the FPU microcontrol and the F-PA unit, and owns the F-PA control lines while busy.

---
 rtl/fpa_pkg.sv | 30 +++
 rtl/fpa_mseq.sv | 196 +++++++++++++++++++
 tb/tb_fpa_mseq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// fpa_pkg: shared definitions for the F-PA mantissa sequencer.
//   fpa_state_e         sequencer states
//   T_HOLD..T_LOAD      T/M register action codes (t_mode, m_mode)
//   K_SUM..K_ZERO       K-bus select codes {lkb,f9}
//   OP_MUL / OP_NORM    operation codes on the op input
package fpa_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ADD  = 3'd2,
        S_SHR  = 3'd3,
        S_NORM = 3'd4,
        S_FIN  = 3'd5
    } fpa_state_e;

    localparam logic [1:0] T_HOLD = 2'b00;
    localparam logic [1:0] T_SHR  = 2'b01;
    localparam logic [1:0] T_SHL  = 2'b10;
    localparam logic [1:0] T_LOAD = 2'b11;

    localparam logic [1:0] K_SUM  = 2'b00;
    localparam logic [1:0] K_M    = 2'b01;
    localparam logic [1:0] K_W    = 2'b10;
    localparam logic [1:0] K_ZERO = 2'b11;

    localparam logic OP_MUL  = 1'b0;
    localparam logic OP_NORM = 1'b1;

endpackage

// File: rtl/fpa_mseq.sv
// fpa_mseq: mantissa sequencer for the F-PA datapath. Turns one start
// request into the per-cycle control word for the T, M and C registers,
// the K-bus select and the ALU mode, for a 40-step two's-complement
// multiply (MUL) or a left normalization (NORM).
//
// Build option: define FPA_NORM_EN to build the NORM sequence. Without it
// op=1 is accepted, spends one busy cycle and finishes with shcnt=0, zero=0.
//
// Ports:
//   clk_sys, rst_n          clock, asynchronous active-low reset
//   start, op               request (IDLE only), 0=MUL 1=NORM
//   m39, m0                 M LSB (current multiplier bit), M sign bit
//   t0_neq_t1, t_zero       T normalized, T all zeros
//   t_mode, m_mode          T/M action: hold, shr, shl, load
//   opt, opm                T / M operate enables
//   k_sel, alu_sub          K-bus select {lkb,f9}, ALU subtract
//   clr_t                   clear T
//   busy, done              sequence in progress, completion pulse
//   shcnt, zero             NORM shift count, NORM found zero mantissa
//
// state  | meaning
// IDLE   | waiting for start, all controls inactive
// CLR    | clear T before the multiply
// ADD    | add multiplicand into T when the multiplier bit is set
// SHR    | shift T:M right one place, advance step
// NORM   | shift T:M left until normalized, zero or saturated
// FIN    | one-cycle done pulse
module fpa_mseq
    import fpa_pkg::*;
#(
    parameter int MW = 40,
    parameter int CW = 6
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic          m39,
    input  logic          m0,
    input  logic          t0_neq_t1,
    input  logic          t_zero,
    output logic [1:0]    t_mode,
    output logic [1:0]    m_mode,
    output logic          opt,
    output logic          opm,
    output logic [1:0]    k_sel,
    output logic          alu_sub,
    output logic          clr_t,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] shcnt,
    output logic          zero
);

    localparam logic [CW-1:0] LAST = CW'(MW - 1);

    fpa_state_e    state_q;
    logic [CW-1:0] step_q;
    logic          norm_shift;

`ifdef FPA_NORM_EN
    logic [CW-1:0] shcnt_q;
    logic          zero_q;
    logic          unused_in;

    assign unused_in = m0;
    // A shift happens only while none of the three exit conditions holds.
    assign norm_shift = (state_q == S_NORM) && !t_zero && !t0_neq_t1
                        && (shcnt_q != LAST);
    assign shcnt = shcnt_q;
    assign zero  = zero_q;
`else
    logic unused_in;

    assign unused_in  = ^{m0, t0_neq_t1, t_zero};
    assign norm_shift = 1'b0;
    assign shcnt      = '0;
    assign zero       = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
`ifdef FPA_NORM_EN
            shcnt_q <= '0;
            zero_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        step_q  <= '0;
`ifdef FPA_NORM_EN
                        shcnt_q <= '0;
                        zero_q  <= 1'b0;
`endif
                        state_q <= (op == OP_MUL) ? S_CLR : S_NORM;
                    end
                end
                S_CLR: begin
                    step_q  <= '0;
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    state_q <= S_SHR;
                end
                S_SHR: begin
                    if (step_q == LAST) begin
                        state_q <= S_FIN;
                    end else begin
                        step_q  <= step_q + CW'(1);
                        state_q <= S_ADD;
                    end
                end
                S_NORM: begin
`ifdef FPA_NORM_EN
                    if (t_zero) begin
                        zero_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else if (t0_neq_t1 || (shcnt_q == LAST)) begin
                        state_q <= S_FIN;
                    end else begin
                        shcnt_q <= shcnt_q + CW'(1);
                    end
`else
                    // Single pass-through cycle keeps op=1 timing equal to
                    // an already-normalized operand.
                    state_q <= S_FIN;
`endif
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Decode of the registered state. The ADD load and the NORM shift are
    // qualified by the live datapath flags because those flags only become
    // valid after the previous cycle's shift has landed.
    always_comb begin
        t_mode  = T_HOLD;
        m_mode  = T_HOLD;
        opt     = 1'b0;
        opm     = 1'b0;
        k_sel   = K_SUM;
        alu_sub = 1'b0;
        clr_t   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_CLR: begin
                busy  = 1'b1;
                clr_t = 1'b1;
            end
            S_ADD: begin
                busy    = 1'b1;
                // The final multiplier bit carries negative weight.
                alu_sub = (step_q == LAST);
                if (m39) begin
                    t_mode = T_LOAD;
                    k_sel  = K_SUM;
                    opt    = 1'b1;
                end
            end
            S_SHR: begin
                busy   = 1'b1;
                t_mode = T_SHR;
                m_mode = T_SHR;
                opt    = 1'b1;
                opm    = 1'b1;
            end
            S_NORM: begin
                busy = 1'b1;
                if (norm_shift) begin
                    t_mode = T_SHL;
                    m_mode = T_SHL;
                    opt    = 1'b1;
                    opm    = 1'b1;
                end
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fpa_mseq.sv
// tb_fpa_mseq: drives fpa_mseq with a behavioural T/M register model in the
// loop and compares latency, control counts and results against figures
// computed directly from the operation's arithmetic.
module tb_fpa_mseq;
    import fpa_pkg::*;

    localparam int MW = 40;
    localparam int CW = 6;

    logic          clk_sys = 1'b0;
    logic          rst_n, start, op, m39, m0, t0_neq_t1, t_zero;
    logic [1:0]    t_mode, m_mode, k_sel;
    logic          opt, opm, alu_sub, clr_t, busy, done, zero;
    logic [CW-1:0] shcnt;

    always #5 clk_sys = ~clk_sys;

    fpa_mseq #(.MW(MW), .CW(CW)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .m39       (m39),
        .m0        (m0),
        .t0_neq_t1 (t0_neq_t1),
        .t_zero    (t_zero),
        .t_mode    (t_mode),
        .m_mode    (m_mode),
        .opt       (opt),
        .opm       (opm),
        .k_sel     (k_sel),
        .alu_sub   (alu_sub),
        .clr_t     (clr_t),
        .busy      (busy),
        .done      (done),
        .shcnt     (shcnt),
        .zero      (zero)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [MW-1:0] mreg, treg, load_mask;
    int n_clr, n_load, n_subload, n_sub, n_shr, n_shl, n_bad, lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_dp();
        m39       = mreg[0];
        m0        = mreg[MW-1];
        t_zero    = (treg == '0);
        t0_neq_t1 = treg[MW-1] ^ treg[MW-2];
    endtask

    // Expected NORM result: shifts until the top two bits differ, capped at MW-1.
    function automatic void norm_ref(input logic [MW-1:0] v, output int n, output bit z);
        n = 0;
        z = (v == '0);
        if (!z) begin
            while ((v[MW-1] == v[MW-2]) && (n < MW-1)) begin
                v = v << 1;
                n++;
            end
        end
    endfunction

    // One operation from start to done, observing outputs at the falling edge
    // and applying the datapath effects after the rising edge.
    task automatic run_op(input logic opv, input logic [MW-1:0] val,
                          input int inject_cyc, input int abort_cyc);
        bit sh_r, sh_l;
        n_clr = 0; n_load = 0; n_subload = 0; n_sub = 0;
        n_shr = 0; n_shl = 0; n_bad = 0; lat = -1; load_mask = '0;
        if (opv == OP_MUL) begin
            mreg = val;
            treg = MW'({$urandom, $urandom});
        end else begin
            treg = val;
            mreg = MW'({$urandom, $urandom});
        end
        drive_dp();
        op    = opv;
        start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
        op    = 1'($urandom);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk_sys);
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", {t_mode, m_mode, opt, opm, k_sel, alu_sub, clr_t,
                                     busy, done, shcnt, zero}, 64'd0);
                repeat (3) begin
                    @(negedge clk_sys);
                    if (done || busy) n_bad++;
                end
                rst_n = 1'b1;
                check("abort_quiet", n_bad, 0);
                return;
            end
            sh_r = 1'b0;
            sh_l = 1'b0;
            if (clr_t) n_clr++;
            if (alu_sub) n_sub++;
            if (k_sel != K_SUM) n_bad++;
            if (busy == done) n_bad++;
            if (opt && t_mode == T_LOAD) begin
                n_load++;
                if (n_shr < MW) load_mask[n_shr] = 1'b1;
                if (alu_sub) n_subload++;
            end
            if (opt && opm && t_mode == T_SHR && m_mode == T_SHR) begin
                n_shr++;
                sh_r = 1'b1;
            end
            if (opt && opm && t_mode == T_SHL && m_mode == T_SHL) begin
                n_shl++;
                sh_l = 1'b1;
            end
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk_sys); #1;
            if (sh_r) begin
                mreg = {treg[0], mreg[MW-1:1]};
                treg = {treg[MW-1], treg[MW-1:1]};
            end
            if (sh_l) begin
                treg = treg << 1;
                mreg = mreg << 1;
            end
            drive_dp();
            start = (cyc == inject_cyc);
        end
        start = 1'b0;
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        check("idle_after", {busy, done}, 0);
    endtask

    task automatic mul_checks(input logic [MW-1:0] val);
        check("mul_lat",     lat,       82);
        check("mul_clr",     n_clr,     1);
        check("mul_shr",     n_shr,     MW);
        check("mul_loads",   n_load,    $countones(val));
        check("mul_mask",    load_mask, val);
        check("mul_subload", n_subload, val[MW-1]);
        check("mul_sub",     n_sub,     1);
        check("mul_shl",     n_shl,     0);
        check("mul_bad",     n_bad,     0);
    endtask

`ifdef FPA_NORM_EN
    task automatic norm_test(input logic [MW-1:0] val, input int inject_cyc);
        int n;
        bit z;
        norm_ref(val, n, z);
        run_op(OP_NORM, val, inject_cyc, 0);
        check("norm_lat",   lat,   n + 2);
        check("norm_shl",   n_shl, n);
        check("norm_shcnt", shcnt, n);
        check("norm_zero",  zero,  z);
        check("norm_other", n_clr + n_shr + n_load, 0);
        check("norm_bad",   n_bad, 0);
    endtask
`endif

    initial begin
        logic [MW-1:0]        v;
        logic signed [MW-1:0] s;
        rst_n = 1'b0; start = 1'b0; op = 1'b0;
        mreg = '0; treg = '0;
        drive_dp();
        repeat (2) @(negedge clk_sys);
        check("rst_outs", {t_mode, m_mode, opt, opm, k_sel, alu_sub, clr_t,
                           busy, done, shcnt, zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        run_op(OP_MUL, '0, 0, 0);
        mul_checks('0);

        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[39] = 1'b1;
        run_op(OP_MUL, v, 0, 0);
        mul_checks(v);

        for (int i = 0; i < 3; i++) begin
            v = MW'({$urandom, $urandom});
            run_op(OP_MUL, v, 0, 0);
            mul_checks(v);
        end

        v = MW'({$urandom, $urandom});
        run_op(OP_MUL, v, 0, 42);
        v = MW'({$urandom, $urandom});
        run_op(OP_MUL, v, 0, 0);
        mul_checks(v);

        v = MW'({$urandom, $urandom});
        run_op(OP_MUL, v, 10, 0);
        mul_checks(v);

`ifdef FPA_NORM_EN
        norm_test(40'h00_8000_0000, 0);
        norm_test('0, 0);
        norm_test(40'h40_0000_0000, 0);
        norm_test({MW{1'b1}}, 0);
        norm_test(40'h00_8000_0000, 3);
        for (int i = 0; i < 4; i++) begin
            s = MW'({$urandom, $urandom});
            s = s >>> $urandom_range(0, 38);
            norm_test(s, 0);
        end
`else
        v = MW'({$urandom, $urandom});
        run_op(OP_NORM, v, 0, 0);
        check("nonorm_lat",   lat,   2);
        check("nonorm_shcnt", shcnt, 0);
        check("nonorm_zero",  zero,  0);
        check("nonorm_shl",   n_shl, 0);
        check("nonorm_bad",   n_bad + n_clr + n_shr + n_load, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
